// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Types and helpers shared by the block-RAM FIFO and its write-side
//   arbiter.
//   - arb_state_t : write-arbiter FSM states.
//   - ceil_log2   : constant-foldable ceil(log2(value)), used for index and
//                   counter widths.
// ---------------------------------------------------------------------------
package fifo_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   // Smallest r with (1 << r) >= value; returns 0 for value <= 1.
   function automatic int ceil_log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin winner selection. The request vector is
//   doubled and shifted right by last_grant+1, so bit 0 of the result is the
//   next requester in round-robin order. The lowest set bit of the low N bits
//   is then the winner's offset from last_grant+1.
//
//   Ports:
//     req        in  N      : request vector
//     last_grant in  IDX_W  : most recently granted index (< N)
//     found      out 1      : at least one request is set
//     winner     out IDX_W  : granted index, valid when found
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic             found,
   output logic [IDX_W-1:0] winner
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] req_rot;
   int             start;
   int             offset;
   int             sum;

   // NOTE: every signal assigned in this block gets a default before any
   // conditional assignment, so no path can leave one unassigned and infer a
   // latch.
   always_comb begin
      start   = int'(last_grant) + 1;
      req_dbl = {req, req};
      req_rot = req_dbl >> start;
      found   = 1'b0;
      offset  = 0;
      // Scan downwards so the lowest set bit is the one that sticks.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            found  = 1'b1;
            offset = i;
         end
      end
      // start <= N and offset <= N-1, so one conditional subtract is a modulo.
      sum = start + offset;
      if (sum >= N) sum = sum - N;
      winner = IDX_W'(sum);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO enqueue port among N_REQ burst
//   requesters. A grant is taken in IDLE (no transfer that cycle) and held
//   in LOCKED until the granted requester's last beat or MAX_BURST beats,
//   whichever comes first. Nothing is written while the FIFO is full.
//
//   Ports:
//     clk          in  1             : clock
//     rstn         in  1             : synchronous active-low reset
//     i_req_valid  in  N_REQ         : per-requester beat valid
//     i_req_data   in  N_REQ*DATA_W  : requester k at [k*DATA_W +: DATA_W]
//     i_req_last   in  N_REQ         : final beat of burst (qualified by valid)
//     o_req_ready  out N_REQ         : beat accepted, one-hot or zero
//     o_wren       out 1             : FIFO write enable
//     o_wrdata     out DATA_W        : FIFO write data (granted slice)
//     i_full       in  1             : FIFO full, zero-latency
//     o_grant_id   out log2(N_REQ)   : current or most recent grant
//     o_busy       out 1             : FSM is LOCKED
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter  int N_REQ     = 4,
   parameter  int DATA_W    = 8,
   parameter  int MAX_BURST = 16,
   localparam int IDX_W     = ceil_log2(N_REQ),
   localparam int CNT_W     = ceil_log2(MAX_BURST + 1)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [N_REQ-1:0]          i_req_valid,
   input  logic [N_REQ*DATA_W-1:0]   i_req_data,
   input  logic [N_REQ-1:0]          i_req_last,
   output logic [N_REQ-1:0]          o_req_ready,
   output logic                      o_wren,
   output logic [DATA_W-1:0]         o_wrdata,
   input  logic                      i_full,
   output logic [IDX_W-1:0]          o_grant_id,
   output logic                      o_busy
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

   arb_state_t       state_rg, state_nx;
   logic [IDX_W-1:0] grant_rg, grant_nx;
   logic [IDX_W-1:0] last_grant_rg, last_grant_nx;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_nx;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             beat;
   logic             rel_beat;

   rr_pick #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req        (i_req_valid),
      .last_grant (last_grant_rg),
      .found      (pick_found),
      .winner     (pick_idx)
   );

   // NOTE: reset is sampled on the clock edge (synchronous); last_grant starts
   // at N_REQ-1 so requester 0 wins the first arbitration.
   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_rg      <= ARB_IDLE;
         grant_rg      <= '0;
         last_grant_rg <= LAST_INIT;
         beat_cnt      <= '0;
      end else begin
         state_rg      <= state_nx;
         grant_rg      <= grant_nx;
         last_grant_rg <= last_grant_nx;
         beat_cnt      <= beat_cnt_nx;
      end
   end

   always_comb begin
      state_nx      = state_rg;
      grant_nx      = grant_rg;
      last_grant_nx = last_grant_rg;
      beat_cnt_nx   = beat_cnt;
      o_req_ready   = '0;
      beat          = 1'b0;
      rel_beat      = 1'b0;

      case (state_rg)
         ARB_IDLE: begin
            if (pick_found) begin
               grant_nx    = pick_idx;
               beat_cnt_nx = '0;
               state_nx    = ARB_LOCKED;
            end
         end

         ARB_LOCKED: begin
            // Ready does not wait for valid: the granted requester sees ready
            // whenever the FIFO can take a word.
            o_req_ready[grant_rg] = !i_full;
            beat     = i_req_valid[grant_rg] & !i_full;
            // Last and the cap can coincide; either way it is one release.
            rel_beat = beat & (i_req_last[grant_rg] | (beat_cnt == CNT_LAST));
            if (rel_beat) begin
               last_grant_nx = grant_rg;
               beat_cnt_nx   = '0;
               state_nx      = ARB_IDLE;
            end else if (beat) begin
               beat_cnt_nx = beat_cnt + 1'b1;
            end
         end

         default: state_nx = ARB_IDLE;
      endcase
   end

   assign o_wren     = beat;
   assign o_wrdata   = i_req_data[int'(grant_rg)*DATA_W +: DATA_W];
   assign o_grant_id = grant_rg;
   assign o_busy     = (state_rg == ARB_LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Table-driven bench for fifo_wr_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=4).
//   Each vector holds one cycle's inputs and the outputs expected in that
//   same cycle; inputs change on the falling edge and outputs are sampled
//   1 ns later. Two hand-written sequences follow the table.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int N_REQ     = 4;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;

   logic                    clk;
   logic                    rstn;
   logic [N_REQ-1:0]        i_req_valid;
   logic [N_REQ*DATA_W-1:0] i_req_data;
   logic [N_REQ-1:0]        i_req_last;
   logic [N_REQ-1:0]        o_req_ready;
   logic                    o_wren;
   logic [DATA_W-1:0]       o_wrdata;
   logic                    i_full;
   logic [1:0]              o_grant_id;
   logic                    o_busy;

   int n_cmp = 0;
   int n_bad = 0;

   fifo_wr_arbiter #(
      .N_REQ     (N_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_req_valid (i_req_valid),
      .i_req_data  (i_req_data),
      .i_req_last  (i_req_last),
      .o_req_ready (o_req_ready),
      .o_wren      (o_wren),
      .o_wrdata    (o_wrdata),
      .i_full      (i_full),
      .o_grant_id  (o_grant_id),
      .o_busy      (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   typedef struct {
      bit         rstn;
      logic [3:0] valid;
      logic [3:0] last;
      bit         full;
      logic [31:0] data;
      logic [3:0] e_ready;
      bit         e_wren;
      bit         chk_data;
      logic [7:0] e_wrdata;
      logic [1:0] e_gid;
      bit         e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input bit rs, input logic [3:0] v, input logic [3:0] l, input bit f,
                          input logic [31:0] d, input logic [3:0] er, input bit ew, input bit cd,
                          input logic [7:0] ewd, input logic [1:0] eg, input bit eb);
      vec_t t;
      t.rstn = rs; t.valid = v; t.last = l; t.full = f; t.data = d;
      t.e_ready = er; t.e_wren = ew; t.chk_data = cd; t.e_wrdata = ewd;
      t.e_gid = eg; t.e_busy = eb;
      vecs.push_back(t);
   endtask

   task automatic drive(input bit rs, input logic [3:0] v, input logic [3:0] l, input bit f,
                        input logic [31:0] d);
      rstn = rs; i_req_valid = v; i_req_last = l; i_full = f; i_req_data = d;
   endtask

   initial begin
      int lat;
      drive(1'b0, '0, '0, 1'b0, 32'h44332211);
      repeat (2) @(posedge clk);

      // ---- reset state: idle, wrdata follows requester 0 ----
      add_vec(1, 4'b0000, 4'b0000, 0, 32'h44332211, 4'b0000, 0, 1, 8'h11, 0, 0);

      // ---- single burst: requester 0, A1 A2 A3 ----
      add_vec(1, 4'b0001, 4'b0000, 0, 32'h000000A1, 4'b0000, 0, 0, 8'h00, 0, 0);
      add_vec(1, 4'b0001, 4'b0000, 0, 32'h000000A1, 4'b0001, 1, 1, 8'hA1, 0, 1);
      add_vec(1, 4'b0001, 4'b0000, 0, 32'h000000A2, 4'b0001, 1, 1, 8'hA2, 0, 1);
      add_vec(1, 4'b0001, 4'b0001, 0, 32'h000000A3, 4'b0001, 1, 1, 8'hA3, 0, 1);
      add_vec(1, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 0, 0);
      // reset so the fairness run starts from requester 0
      add_vec(0, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 0, 0);

      // ---- round-robin: all valid, last every beat -> 0,1,2,3,0 ----
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b0000, 0, 0, 8'h00, 0, 0);
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b0001, 1, 1, 8'h10, 0, 1);
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b0000, 0, 0, 8'h00, 0, 0);
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b0010, 1, 1, 8'h21, 1, 1);
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b0000, 0, 0, 8'h00, 1, 0);
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b0100, 1, 1, 8'h32, 2, 1);
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b0000, 0, 0, 8'h00, 2, 0);
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b1000, 1, 1, 8'h43, 3, 1);
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b0000, 0, 0, 8'h00, 3, 0);
      add_vec(1, 4'b1111, 4'b1111, 0, 32'h43322110, 4'b0001, 1, 1, 8'h10, 0, 1);
      add_vec(1, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 0, 0);

      // ---- backpressure: requester 1, full for 5 cycles after beat 2;
      //      no last, so release on beat 4 only if the count held at 2 ----
      add_vec(1, 4'b0010, 4'b0000, 0, 32'h0000B100, 4'b0000, 0, 0, 8'h00, 0, 0);
      add_vec(1, 4'b0010, 4'b0000, 0, 32'h0000B100, 4'b0010, 1, 1, 8'hB1, 1, 1);
      add_vec(1, 4'b0010, 4'b0000, 0, 32'h0000B200, 4'b0010, 1, 1, 8'hB2, 1, 1);
      for (int i = 0; i < 5; i++)
         add_vec(1, 4'b0010, 4'b0000, 1, 32'h0000B300, 4'b0000, 0, 0, 8'h00, 1, 1);
      add_vec(1, 4'b0010, 4'b0000, 0, 32'h0000B300, 4'b0010, 1, 1, 8'hB3, 1, 1);
      add_vec(1, 4'b0010, 4'b0000, 0, 32'h0000B400, 4'b0010, 1, 1, 8'hB4, 1, 1);
      add_vec(1, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 1, 0);

      // ---- burst cap: requester 2 never lasts, requester 3 waits ----
      add_vec(1, 4'b1100, 4'b1000, 0, 32'hE3C20000, 4'b0000, 0, 0, 8'h00, 1, 0);
      for (int i = 0; i < MAX_BURST; i++)
         add_vec(1, 4'b1100, 4'b1000, 0, 32'hE3C20000, 4'b0100, 1, 1, 8'hC2, 2, 1);
      add_vec(1, 4'b1100, 4'b1000, 0, 32'hE3C20000, 4'b0000, 0, 0, 8'h00, 2, 0);
      add_vec(1, 4'b1100, 4'b1000, 0, 32'hE3C20000, 4'b1000, 1, 1, 8'hE3, 3, 1);
      add_vec(1, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 3, 0);

      // ---- valid gap: requester 0 drops valid 3 cycles, requester 1 waits ----
      add_vec(1, 4'b0011, 4'b0000, 0, 32'h00005F51, 4'b0000, 0, 0, 8'h00, 3, 0);
      add_vec(1, 4'b0011, 4'b0000, 0, 32'h00005F51, 4'b0001, 1, 1, 8'h51, 0, 1);
      for (int i = 0; i < 3; i++)
         add_vec(1, 4'b0010, 4'b0000, 0, 32'h00005F52, 4'b0001, 0, 0, 8'h00, 0, 1);
      add_vec(1, 4'b0011, 4'b0000, 0, 32'h00005F52, 4'b0001, 1, 1, 8'h52, 0, 1);
      add_vec(1, 4'b0011, 4'b0001, 0, 32'h00005F53, 4'b0001, 1, 1, 8'h53, 0, 1);
      add_vec(1, 4'b0010, 4'b0010, 0, 32'h00005F00, 4'b0000, 0, 0, 8'h00, 0, 0);
      add_vec(1, 4'b0010, 4'b0010, 0, 32'h00005F00, 4'b0010, 1, 1, 8'h5F, 1, 1);
      add_vec(1, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 1, 0);

      // ---- reset mid-burst: requester 2, reset during beat 2 ----
      add_vec(1, 4'b0100, 4'b0000, 0, 32'h00610000, 4'b0000, 0, 0, 8'h00, 1, 0);
      add_vec(1, 4'b0100, 4'b0000, 0, 32'h00610000, 4'b0100, 1, 1, 8'h61, 2, 1);
      add_vec(0, 4'b0100, 4'b0000, 0, 32'h00620000, 4'b0100, 1, 1, 8'h62, 2, 1);
      add_vec(1, 4'b0101, 4'b0000, 0, 32'h00630070, 4'b0000, 0, 1, 8'h70, 0, 0);
      add_vec(1, 4'b0101, 4'b0001, 0, 32'h00630070, 4'b0001, 1, 1, 8'h70, 0, 1);
      add_vec(1, 4'b0100, 4'b0000, 0, 32'h00630000, 4'b0000, 0, 0, 8'h00, 0, 0);
      add_vec(1, 4'b0100, 4'b0100, 0, 32'h00630000, 4'b0100, 1, 1, 8'h63, 2, 1);
      add_vec(1, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 0, 8'h00, 2, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].rstn, vecs[i].valid, vecs[i].last, vecs[i].full, vecs[i].data);
         #1;
         check($sformatf("v%0d.ready", i), 32'(o_req_ready), 32'(vecs[i].e_ready));
         check($sformatf("v%0d.wren",  i), 32'(o_wren),      32'(vecs[i].e_wren));
         check($sformatf("v%0d.gid",   i), 32'(o_grant_id),  32'(vecs[i].e_gid));
         check($sformatf("v%0d.busy",  i), 32'(o_busy),      32'(vecs[i].e_busy));
         if (vecs[i].chk_data)
            check($sformatf("v%0d.wrdata", i), 32'(o_wrdata), 32'(vecs[i].e_wrdata));
      end

      // ---- arbitration latency: requester 3 alone, bounded wait for wren ----
      @(negedge clk);
      drive(1'b1, 4'b1000, 4'b1000, 1'b0, 32'h99000000);
      #1;
      lat = -1;
      for (int c = 0; c < 8; c++) begin
         if (o_wren) begin
            lat = c;
            break;
         end
         @(negedge clk);
         #1;
      end
      check("lat.cycles", 32'(lat), 32'd1);
      check("lat.wrdata", 32'(o_wrdata), 32'h99);
      check("lat.gid",    32'(o_grant_id), 32'd3);
      @(negedge clk);
      drive(1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0);
      #1;
      check("lat.release", 32'(o_busy), 32'd0);

      // ---- full at grant time: grant taken, nothing written until !full ----
      @(negedge clk);
      drive(1'b1, 4'b0001, 4'b0001, 1'b1, 32'h0000005A);
      #1;
      check("fg.idle_busy", 32'(o_busy), 32'd0);
      @(negedge clk);
      #1;
      check("fg.busy",  32'(o_busy), 32'd1);
      check("fg.ready", 32'(o_req_ready), 32'd0);
      check("fg.wren",  32'(o_wren), 32'd0);
      @(negedge clk);
      i_full = 1'b0;
      #1;
      check("fg.ready2", 32'(o_req_ready), 32'b0001);
      check("fg.wren2",  32'(o_wren), 32'd1);
      check("fg.data2",  32'(o_wrdata), 32'h5A);
      @(negedge clk);
      drive(1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0);
      #1;
      check("fg.release", 32'(o_busy), 32'd0);
      check("fg.gid",     32'(o_grant_id), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
